rf_scoreboard_regfile: RTL and testbench

//   Parametrised integer register file for the pipelined RISC-V core.
//   Two combinational read ports, one write-back port with write-to-read bypass.

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_scoreboard_regfile_if.sv | 19 +
 rtl/rf_pending_ctr.sv | 25 ++
 rtl/rf_scoreboard_regfile.sv | 45 ++++
 tb/tb_rf_scoreboard_regfile.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared sizes, reset constants and types for the scoreboarded register file
package rf_pkg;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = $clog2(NREGS);
  localparam int CW = 2;
  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0] reg_data_t;
  typedef logic [CW-1:0] cnt_t;
  localparam reg_addr_t ZERO_REG = '0;
  localparam reg_addr_t SP_IDX = reg_addr_t'(2);
  localparam reg_data_t SP_RESET = reg_data_t'(32'h500);
endpackage

// File: rtl/rf_scoreboard_regfile_if.sv
// rf_scoreboard_regfile_if: decode/write-back bus of the register file
//   read:  rs1_addr, rs2_addr -> rs1_data, rs2_data, rs1_busy, rs2_busy
//   issue: issue_en, issue_rd -> issue_full
//   wb:    wb_en, wb_addr, wb_data; flush
//   master = pipeline side, slave = register file
interface rf_scoreboard_regfile_if;
  import rf_pkg::*;
  reg_addr_t rs1_addr, rs2_addr, issue_rd, wb_addr;
  reg_data_t rs1_data, rs2_data, wb_data;
  logic rs1_busy, rs2_busy, issue_en, issue_full, wb_en, flush;
  modport master (
    output rs1_addr, rs2_addr, issue_en, issue_rd, wb_en, wb_addr, wb_data, flush,
    input rs1_data, rs2_data, rs1_busy, rs2_busy, issue_full
  );
  modport slave (
    input rs1_addr, rs2_addr, issue_en, issue_rd, wb_en, wb_addr, wb_data, flush,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, issue_full
  );
endinterface

// File: rtl/rf_pending_ctr.sv
// rf_pending_ctr: saturating pending-write counter, inc/dec cancel, clr wins, no underflow
//   clk, rst: clock, sync active-high reset
//   inc_i, dec_i, clr_i: count up, count down, clear
//   cnt_o: current count; full_o: count at maximum
module rf_pending_ctr
  import rf_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  input  logic clr_i,
  output cnt_t cnt_o,
  output logic full_o
);
  cnt_t cnt_q, cnt_d;
  assign cnt_o = cnt_q;
  assign full_o = &cnt_q;
  always_comb
    cnt_d = clr_i ? '0 :
            (inc_i && !dec_i && !full_o) ? cnt_q + cnt_t'(1) :
            (dec_i && !inc_i && cnt_q != '0) ? cnt_q - cnt_t'(1) : cnt_q;
  always_ff @(posedge clk)
    cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/rf_scoreboard_regfile.sv
// rf_scoreboard_regfile: 2R/1W register file with write bypass and per-register pending-write scoreboard
//   clk, rst: clock, sync active-high reset
//   bus (slave): read ports with busy flags, issue port with full flag, write-back port, flush
module rf_scoreboard_regfile
  import rf_pkg::*;
(
  input logic clk,
  input logic rst,
  rf_scoreboard_regfile_if.slave bus
);
  reg_data_t regs_q [NREGS];
  logic [NREGS-1:0][CW-1:0] cnt;
  logic [NREGS-1:0] sat;
  logic byp1, byp2;
  assign cnt[0] = '0;
  assign sat[0] = 1'b0;
  // a write-back to the same register frees a slot, so a saturated issue may proceed
  assign bus.issue_full = bus.issue_en && bus.issue_rd != ZERO_REG && sat[bus.issue_rd] &&
                          !(bus.wb_en && bus.wb_addr == bus.issue_rd);
  for (genvar g = 1; g < NREGS; g++) begin : g_ctr
    rf_pending_ctr u_ctr (
      .clk    (clk),
      .rst    (rst),
      .inc_i  (bus.issue_en && bus.issue_rd == reg_addr_t'(g) && !bus.issue_full),
      .dec_i  (bus.wb_en && bus.wb_addr == reg_addr_t'(g)),
      .clr_i  (bus.flush),
      .cnt_o  (cnt[g]),
      .full_o (sat[g])
    );
  end
  assign byp1 = bus.wb_en && bus.wb_addr == bus.rs1_addr;
  assign byp2 = bus.wb_en && bus.wb_addr == bus.rs2_addr;
  assign bus.rs1_data = bus.rs1_addr == ZERO_REG ? '0 : byp1 ? bus.wb_data : regs_q[bus.rs1_addr];
  assign bus.rs2_data = bus.rs2_addr == ZERO_REG ? '0 : byp2 ? bus.wb_data : regs_q[bus.rs2_addr];
  // the last outstanding write completing this cycle is already bypassed, so it no longer blocks
  assign bus.rs1_busy = bus.rs1_addr != ZERO_REG && cnt[bus.rs1_addr] > cnt_t'(byp1);
  assign bus.rs2_busy = bus.rs2_addr != ZERO_REG && cnt[bus.rs2_addr] > cnt_t'(byp2);
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      regs_q[SP_IDX] <= SP_RESET;
    end else if (bus.wb_en && bus.wb_addr != ZERO_REG) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
    end
endmodule

// File: tb/tb_rf_scoreboard_regfile.sv
// tb_rf_scoreboard_regfile: directed and mixed stimulus against an array/counter reference model
module tb_rf_scoreboard_regfile;
  logic clk = 0, rst = 0, chk_en = 0;
  int total = 0, bad = 0;
  logic [31:0] m_reg [32];
  int m_cnt [32];

  rf_scoreboard_regfile_if bus ();
  rf_scoreboard_regfile dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  // reference state advances on each rising edge from the inputs held across it
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_cnt[i] = 0; end
      m_reg[2] = 32'h500;
    end else begin
      if (bus.wb_en && bus.wb_addr != 0) m_reg[bus.wb_addr] = bus.wb_data;
      if (bus.flush) begin
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      end else begin
        if (bus.issue_en && bus.issue_rd != 0 &&
            !(m_cnt[bus.issue_rd] == 3 && !(bus.wb_en && bus.wb_addr == bus.issue_rd)))
          m_cnt[bus.issue_rd]++;
        if (bus.wb_en && bus.wb_addr != 0 && m_cnt[bus.wb_addr] > 0) m_cnt[bus.wb_addr]--;
      end
    end
  endtask

  function automatic logic [31:0] e_data(input logic [4:0] a);
    if (a == 0) return 0;
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    return m_reg[a];
  endfunction

  function automatic logic e_busy(input logic [4:0] a);
    int pend;
    pend = (a == 0) ? 0 : m_cnt[a];
    if (bus.wb_en && bus.wb_addr == a && pend > 0) pend--;
    return pend > 0;
  endfunction

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cmp_rs1_data", bus.rs1_data, e_data(bus.rs1_addr));
      check("cmp_rs2_data", bus.rs2_data, e_data(bus.rs2_addr));
      check("cmp_rs1_busy", 32'(bus.rs1_busy), 32'(e_busy(bus.rs1_addr)));
      check("cmp_rs2_busy", 32'(bus.rs2_busy), 32'(e_busy(bus.rs2_addr)));
      check("cmp_full", 32'(bus.issue_full),
            32'(bus.issue_en && bus.issue_rd != 0 && m_cnt[bus.issue_rd] == 3 &&
                !(bus.wb_en && bus.wb_addr == bus.issue_rd)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear();
    rst = 0;
    bus.rs1_addr = 0; bus.rs2_addr = 0; bus.issue_en = 0; bus.issue_rd = 0;
    bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0; bus.flush = 0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en = 1; bus.wb_addr = a; bus.wb_data = d;
  endtask

  task automatic iss(input logic [4:0] a);
    bus.issue_en = 1; bus.issue_rd = a;
  endtask

  initial begin
    clear();
    rst = 1;
    cyc();
    clear();
    chk_en = 1;
    bus.rs1_addr = 2; bus.rs2_addr = 5; #2;
    check("rst_sp", bus.rs1_data, 32'h500);
    check("rst_x5", bus.rs2_data, 0);
    check("rst_busy1", 32'(bus.rs1_busy), 0);
    check("rst_busy2", 32'(bus.rs2_busy), 0);
    check("rst_full", 32'(bus.issue_full), 0);
    cyc(); clear();
    wb(7, 32'hDEADBEEF); bus.rs1_addr = 7; bus.rs2_addr = 7; #2;
    check("byp_rs1", bus.rs1_data, 32'hDEADBEEF);
    check("byp_rs2", bus.rs2_data, 32'hDEADBEEF);
    cyc(); clear();
    bus.rs1_addr = 7; bus.rs2_addr = 7; #2;
    check("wr_rs1", bus.rs1_data, 32'hDEADBEEF);
    check("wr_rs2", bus.rs2_data, 32'hDEADBEEF);
    cyc(); clear();
    wb(0, 32'h1234); iss(0); #2;
    check("x0_data", bus.rs1_data, 0);
    check("x0_busy", 32'(bus.rs1_busy), 0);
    check("x0_full", 32'(bus.issue_full), 0);
    cyc(); clear();
    iss(0); #2;
    check("x0_data2", bus.rs1_data, 0);
    check("x0_busy2", 32'(bus.rs1_busy), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); clear();
      iss(9); bus.rs1_addr = 9; #2;
      check("sb_nofull", 32'(bus.issue_full), 0);
    end
    cyc(); clear();
    iss(9); bus.rs1_addr = 9; #2;
    check("sb_full", 32'(bus.issue_full), 1);
    check("sb_busy", 32'(bus.rs1_busy), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(); clear();
      wb(9, 32'h900 + 32'(i)); bus.rs1_addr = 9; #2;
      check("sb_wb_busy", 32'(bus.rs1_busy), (i < 2) ? 1 : 0);
      check("sb_wb_data", bus.rs1_data, 32'h900 + 32'(i));
    end
    cyc(); clear();
    bus.rs1_addr = 9; #2;
    check("sb_idle_busy", 32'(bus.rs1_busy), 0);
    check("sb_idle_data", bus.rs1_data, 32'h902);
    cyc(); clear();
    iss(4);
    cyc(); clear();
    iss(4); wb(4, 32'hAAAA); bus.rs1_addr = 4; #2;
    check("sim_full", 32'(bus.issue_full), 0);
    check("sim_busy_now", 32'(bus.rs1_busy), 0);
    cyc(); clear();
    bus.rs1_addr = 4; #2;
    check("sim_busy_after", 32'(bus.rs1_busy), 1);
    check("sim_data", bus.rs1_data, 32'hAAAA);
    cyc(); clear();
    bus.flush = 1; iss(4); wb(6, 32'h66); bus.rs1_addr = 4; bus.rs2_addr = 6; #2;
    check("fl_busy_now", 32'(bus.rs1_busy), 1);
    cyc(); clear();
    bus.rs1_addr = 4; bus.rs2_addr = 6; #2;
    check("fl_busy1", 32'(bus.rs1_busy), 0);
    check("fl_busy2", 32'(bus.rs2_busy), 0);
    check("fl_data4", bus.rs1_data, 32'hAAAA);
    check("fl_data6", bus.rs2_data, 32'h66);
    cyc(); clear();
    wb(3, 32'h55);
    cyc(); clear();
    iss(3);
    cyc(); clear();
    iss(3);
    cyc(); clear();
    bus.rs1_addr = 3; #2;
    check("mid_busy", 32'(bus.rs1_busy), 1);
    check("mid_data", bus.rs1_data, 32'h55);
    cyc(); clear();
    rst = 1; wb(3, 32'h77); iss(3); bus.rs1_addr = 3;
    cyc(); clear();
    bus.rs1_addr = 3; bus.rs2_addr = 2; #2;
    check("rstmid_data", bus.rs1_data, 0);
    check("rstmid_busy", 32'(bus.rs1_busy), 0);
    check("rstmid_sp", bus.rs2_data, 32'h500);
    for (int i = 0; i < 400; i++) begin
      cyc(); clear();
      bus.rs1_addr = 5'($urandom_range(0, 7));
      bus.rs2_addr = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) iss(5'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) wb(5'($urandom_range(0, 7)), $urandom);
      bus.flush = ($urandom_range(0, 23) == 0);
      rst = ($urandom_range(0, 79) == 0);
    end
    cyc(); clear();
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
